// File: rtl/flaf_pkg.sv
// Shared definitions for the functional-link adaptive filter datapath:
// default word formats, the update-engine state encoding and saturation limits.
package flaf_pkg;

  localparam int FLAF_WIDTH     = 16;
  localparam int FLAF_QP        = 12;
  localparam int FLAF_LOG_WIDTH = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/antilog_q12.sv
// Mitchell antilog: turns a signed log2 magnitude (integer part k, fraction f)
// into the linear magnitude (1.f) * 2^k in Q(QP), with underflow to 0 and saturation.
module antilog_q12
  import flaf_pkg::*;
#(
  parameter int WIDTH     = FLAF_WIDTH,
  parameter int QP        = FLAF_QP,
  parameter int LOG_WIDTH = FLAF_LOG_WIDTH
) (
  input  logic [LOG_WIDTH:0] i_sum,
  input  logic               i_valid,
  output logic [WIDTH-1:0]   o_mag
);

  localparam int KW = LOG_WIDTH + 1 - QP;
  localparam int SW = QP + 1 + WIDTH;
  localparam logic signed [KW-1:0] K_UNDER = KW'(-(QP + 1));
  localparam logic signed [KW-1:0] K_OVER  = KW'(WIDTH);
  localparam logic [SW-1:0]        MAG_MAX = SW'(sat_max(WIDTH));

  logic signed [KW-1:0] w_k;
  logic [KW-1:0]        w_rsh_amt;
  logic [QP:0]          w_m;
  logic [SW-1:0]        w_lsh;
  logic [SW-1:0]        w_rsh;

  assign w_k       = $signed(i_sum[LOG_WIDTH:QP]);
  assign w_rsh_amt = -w_k;
  assign w_m       = {1'b1, i_sum[QP-1:0]};
  // Left shift is only used for 0 <= k < WIDTH, so SW bits never overflow.
  assign w_lsh     = SW'(w_m) << w_k;
  assign w_rsh     = SW'(w_m) >> w_rsh_amt;

  // NOTE: o_mag gets a default first so no path through the if-chain can infer a latch.
  always_comb begin
    o_mag = '0;
    if (!i_valid || (w_k < K_UNDER)) begin
      o_mag = '0;
    end else if (w_k >= K_OVER) begin
      o_mag = MAG_MAX[WIDTH-1:0];
    end else if (w_k >= 0) begin
      o_mag = (w_lsh > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : w_lsh[WIDTH-1:0];
    end else begin
      o_mag = w_rsh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/log_weight_update.sv
// Log-domain LMS weight update: walks every tap once per start, adds the latched
// log error to the tap's log input, antilogs the sum and saturating-adds it to the weight.
module log_weight_update
  import flaf_pkg::*;
#(
  parameter int WIDTH     = FLAF_WIDTH,
  parameter int QP        = FLAF_QP,
  parameter int LOG_WIDTH = FLAF_LOG_WIDTH,
  parameter int TAPS      = 8,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 weight_clear,
  input  logic [LOG_WIDTH-1:0] log_error,
  input  logic                 log_error_sign,
  input  logic                 log_error_valid,
  output logic [IDX_W-1:0]     tap_idx,
  input  logic [LOG_WIDTH-1:0] tap_log,
  input  logic                 tap_sign,
  input  logic                 tap_valid,
  input  logic [IDX_W-1:0]     weight_rd_idx,
  output logic [WIDTH-1:0]     weight_rd_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic signed [WIDTH:0] W_MAX    = (WIDTH + 1)'(sat_max(WIDTH));
  localparam logic signed [WIDTH:0] W_MIN    = (WIDTH + 1)'(sat_min(WIDTH));
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(TAPS - 1);

  state_t                r_state;
  logic [LOG_WIDTH-1:0]  r_err;
  logic                  r_err_sign;
  logic                  r_err_valid;
  logic [IDX_W-1:0]      r_tap_idx;
  logic                  r_busy;
  logic                  r_done;
  logic [LOG_WIDTH:0]    r_s1_sum;
  logic                  r_s1_sign;
  logic                  r_s1_valid;
  logic                  r_s1_wen;
  logic [IDX_W-1:0]      r_s1_idx;
  logic [WIDTH-1:0]      r_weight [TAPS];

  logic [WIDTH-1:0]      w_mag;
  logic signed [WIDTH:0] w_old;
  logic signed [WIDTH:0] w_delta;
  logic signed [WIDTH:0] w_sum;
  logic [WIDTH-1:0]      w_new;

  antilog_q12 #(
    .WIDTH     (WIDTH),
    .QP        (QP),
    .LOG_WIDTH (LOG_WIDTH)
  ) u_antilog (
    .i_sum   (r_s1_sum),
    .i_valid (r_s1_valid),
    .o_mag   (w_mag)
  );

  // An invalid product yields mag 0, so the delta is already 0 for that tap.
  assign w_old   = $signed({r_weight[r_s1_idx][WIDTH-1], r_weight[r_s1_idx]});
  assign w_delta = r_s1_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  assign w_sum   = w_old + w_delta;
  assign w_new   = (w_sum > W_MAX) ? W_MAX[WIDTH-1:0] :
                   (w_sum < W_MIN) ? W_MIN[WIDTH-1:0] : w_sum[WIDTH-1:0];

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_err       <= '0;
      r_err_sign  <= 1'b0;
      r_err_valid <= 1'b0;
      r_tap_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_sign   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_wen    <= 1'b0;
      r_s1_idx    <= '0;
    end else begin
      r_s1_wen <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !weight_clear) begin
            r_state     <= ST_RUN;
            r_err       <= log_error;
            r_err_sign  <= log_error_sign;
            r_err_valid <= log_error_valid;
            r_tap_idx   <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          r_s1_sum   <= {r_err[LOG_WIDTH-1], r_err} + {tap_log[LOG_WIDTH-1], tap_log};
          r_s1_sign  <= r_err_sign ^ tap_sign;
          r_s1_valid <= r_err_valid & tap_valid;
          r_s1_idx   <= r_tap_idx;
          r_s1_wen   <= 1'b1;
          if (r_tap_idx == LAST_IDX) begin
            r_tap_idx <= '0;
            r_state   <= ST_DRAIN;
          end else begin
            r_tap_idx <= r_tap_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the weight file is reset explicitly; an aborted run must leave no stale weights behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_weight[i] <= '0;
    end else if ((r_state == ST_IDLE) && weight_clear) begin
      for (int i = 0; i < TAPS; i++) r_weight[i] <= '0;
    end else if (r_s1_wen) begin
      r_weight[r_s1_idx] <= w_new;
    end
  end

  assign tap_idx        = r_tap_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign weight_rd_data = r_weight[weight_rd_idx];

endmodule

// File: tb/tb_log_weight_update.sv
// Directed bench for log_weight_update: an arithmetic reference model tracks expected
// weights and handshake outputs, and a compare process checks the DUT every cycle.
`timescale 1ns/1ps
module tb_log_weight_update;

  localparam int WIDTH     = 16;
  localparam int QP        = 12;
  localparam int LOG_WIDTH = 17;
  localparam int TAPS      = 8;
  localparam int IDX_W     = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 weight_clear = 1'b0;
  logic [LOG_WIDTH-1:0] log_error = '0;
  logic                 log_error_sign = 1'b0;
  logic                 log_error_valid = 1'b0;
  logic [IDX_W-1:0]     tap_idx;
  logic [LOG_WIDTH-1:0] tap_log;
  logic                 tap_sign;
  logic                 tap_valid;
  logic [IDX_W-1:0]     weight_rd_idx = '0;
  logic [WIDTH-1:0]     weight_rd_data;
  logic                 busy;
  logic                 done;

  // Tap source: combinational lookup by the DUT's tap index.
  int tb_tlog   [TAPS];
  bit tb_tsign  [TAPS];
  bit tb_tvalid [TAPS];

  assign tap_log   = LOG_WIDTH'(tb_tlog[tap_idx]);
  assign tap_sign  = tb_tsign[tap_idx];
  assign tap_valid = tb_tvalid[tap_idx];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase = edges since the accepted start, -1 when idle.
  int phase = -1;
  int m_w [TAPS] = '{default: 0};
  int m_err = 0;
  bit m_esign = 1'b0;
  bit m_evalid = 1'b0;

  log_weight_update #(
    .WIDTH (WIDTH), .QP (QP), .LOG_WIDTH (LOG_WIDTH), .TAPS (TAPS), .IDX_W (IDX_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .weight_clear    (weight_clear),
    .log_error       (log_error),
    .log_error_sign  (log_error_sign),
    .log_error_valid (log_error_valid),
    .tap_idx         (tap_idx),
    .tap_log         (tap_log),
    .tap_sign        (tap_sign),
    .tap_valid       (tap_valid),
    .weight_rd_idx   (weight_rd_idx),
    .weight_rd_data  (weight_rd_data),
    .busy            (busy),
    .done            (done)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Linear magnitude of 2^(sum/4096) in Q12, floor-truncated, clamped to the weight range.
  function automatic int model_mag(input int sum);
    int     k;
    int     f;
    longint m;
    k = sum >>> QP;
    f = sum - k * (1 << QP);
    if (k < -(QP + 1)) return 0;
    if (k >= WIDTH) return 32767;
    m = longint'((1 << QP) + f);
    if (k >= 0) begin
      m = m * (longint'(1) << k);
      if (m > 32767) m = 32767;
    end else begin
      m = m / (longint'(1) << (-k));
    end
    return int'(m);
  endfunction

  function automatic int clamp_w(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_apply(input int j);
    int mag;
    int delta;
    mag   = model_mag(m_err + tb_tlog[j]);
    delta = (m_evalid && tb_tvalid[j]) ? ((m_esign ^ tb_tsign[j]) ? -mag : mag) : 0;
    m_w[j] = clamp_w(m_w[j] + delta);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      phase = -1;
      for (int i = 0; i < TAPS; i++) m_w[i] = 0;
    end else if (phase == -1) begin
      if (weight_clear) begin
        for (int i = 0; i < TAPS; i++) m_w[i] = 0;
      end else if (start) begin
        phase    = 0;
        m_err    = int'($signed(log_error));
        m_esign  = log_error_sign;
        m_evalid = log_error_valid;
      end
    end else begin
      phase++;
      if (phase >= 2 && phase <= TAPS + 1) model_apply(phase - 2);
      if (phase == TAPS + 2) phase = -1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("busy", longint'(busy), longint'(phase >= 0 && phase <= TAPS));
      check("done", longint'(done), longint'(phase == TAPS + 1));
      check("tap_idx", longint'(tap_idx), longint'((phase >= 0 && phase < TAPS) ? phase : 0));
      for (int i = 0; i < TAPS; i++) begin
        weight_rd_idx = IDX_W'(i);
        #1;
        check($sformatf("weight[%0d]", i), longint'($signed(weight_rd_data)), longint'(m_w[i]));
      end
    end
  end

  task automatic set_err(input int v, input bit s, input bit valid);
    log_error       = LOG_WIDTH'(v);
    log_error_sign  = s;
    log_error_valid = valid;
  endtask

  task automatic set_taps(input int v, input bit s, input bit valid);
    for (int i = 0; i < TAPS; i++) begin
      tb_tlog[i]   = v;
      tb_tsign[i]  = s;
      tb_tvalid[i] = valid;
    end
  endtask

  task automatic clear_weights();
    @(posedge clk); #1 weight_clear = 1'b1;
    @(posedge clk); #1 weight_clear = 1'b0;
  endtask

  // One update run; optionally pokes start again while busy.
  task automatic do_run(input bit poke);
    int n;
    bit seen;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      if (poke && n == 4) begin
        #2 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    check("done_latency", n, TAPS + 2);
  endtask

  initial begin
    int  ndone;
    bit  found;
    set_err(0, 1'b0, 1'b0);
    set_taps(0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_tap_idx", longint'(tap_idx), 0);
    rst = 1'b0;

    check("pin_mag_half", model_mag(-4096), 2048);
    check("pin_mag_k0", model_mag(2048), 6144);
    check("pin_mag_sat", model_mag(16384), 32767);
    check("pin_mag_under", model_mag(-14 * 4096), 0);

    set_err(-4096, 1'b0, 1'b1);
    set_taps(0, 1'b0, 1'b1);
    do_run(1'b0);
    check("pin_half_w0", m_w[0], 2048);
    check("pin_half_w7", m_w[7], 2048);

    clear_weights();
    set_err(-4096, 1'b1, 1'b1);
    do_run(1'b0);
    check("pin_neg_half", m_w[4], -2048);
    set_taps(0, 1'b1, 1'b1);
    do_run(1'b0);
    check("pin_back_zero", m_w[4], 0);

    clear_weights();
    set_err(8192, 1'b0, 1'b1);
    set_taps(8192, 1'b0, 1'b1);
    do_run(1'b0);
    check("pin_sat_pos", m_w[2], 32767);
    do_run(1'b0);
    check("pin_sat_hold", m_w[2], 32767);
    clear_weights();
    set_err(8192, 1'b1, 1'b1);
    do_run(1'b0);
    check("pin_sat_neg1", m_w[5], -32767);
    do_run(1'b0);
    check("pin_sat_neg2", m_w[5], -32768);

    clear_weights();
    set_err(2048, 1'b0, 1'b1);
    set_taps(0, 1'b0, 1'b1);
    do_run(1'b0);
    check("pin_k0", m_w[1], 6144);
    set_err(-14 * 4096, 1'b0, 1'b1);
    do_run(1'b0);
    check("pin_underflow", m_w[1], 6144);
    set_err(2048, 1'b0, 1'b0);
    do_run(1'b0);
    check("pin_err_invalid", m_w[6], 6144);
    set_err(2048, 1'b0, 1'b1);
    tb_tvalid[3] = 1'b0;
    do_run(1'b0);
    check("pin_tap3_hold", m_w[3], 6144);
    check("pin_tap0_add", m_w[0], 12288);
    tb_tvalid[3] = 1'b1;

    do_run(1'b1);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_extra_done", ndone, 0);
    check("pin_after_poke", m_w[0], 18432);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (tap_idx == IDX_W'(4)) found = 1'b1;
    end
    check("reach_idx4", longint'(found), 1);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_tap_idx", longint'(tap_idx), 0);
    check("abort_weight", longint'($signed(weight_rd_data)), 0);
    @(posedge clk); #3 rst = 1'b0;
    do_run(1'b0);
    check("pin_after_abort", m_w[3], 6144);

    @(posedge clk); #1 begin weight_clear = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin weight_clear = 1'b0; start = 1'b0; end
    check("clear_wins_busy", longint'(busy), 0);
    check("pin_cleared", m_w[0], 0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
